// File: rtl/vga_timing_pkg.sv
// VGA 800x600 timing constants, lock FSM states and pixel type
// shared by the capture monitor and the display driver.
package vga_timing_pkg;

  localparam int H_SYNC_800 = 128;
  localparam int H_BACK_800 = 88;
  localparam int H_ACT_800 = 800;
  localparam int H_PER_800 = 1056;
  localparam int V_SYNC_600 = 4;
  localparam int V_BACK_600 = 23;
  localparam int V_ACT_600 = 600;
  localparam int V_PER_600 = 628;

  localparam int CW = 11;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKED
  } lock_st_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_sync_meter.sv
// Sync edge detector with saturating counter and width/period checks.
// cnt_o is the post-update count of the current cycle.
module vga_sync_meter
  import vga_timing_pkg::*;
#(
  parameter int W_SYNC = 128,
  parameter int PERIOD = 1056
) (
  input  logic          clk_vga,
  input  logic          reset_n,
  input  logic          sync_i,
  input  logic          step_i,
  output logic          fall_o,
  output logic          rise_o,
  output logic [CW-1:0] cnt_o,
  output logic          err_width_o,
  output logic          err_period_o
);

  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat;

  assign fall_o = prev_q & ~sync_i;
  assign rise_o = ~prev_q & sync_i;
  assign sat    = step_i & (cnt_q == CNT_MAX);
  assign cnt_o  = cnt_d;

  // count steps since the last falling edge, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (fall_o) cnt_d = '0;
    else if (step_i && !sat) cnt_d = cnt_q + 1'b1;
  end

  // width checked on rise, period checked on fall
  always_comb begin
    err_width_o  = rise_o && (int'(cnt_d) != W_SYNC);
    err_period_o = (fall_o && (int'(cnt_q) + 1 != PERIOD))
                || (sat && !fall_o);
  end

  // edge history and counter state
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= sync_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_capture_monitor.sv
// Passive VGA receiver: sync checking, lock acquisition and
// coordinate-tagged pixel capture with per-frame checksum.
module vga_capture_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = H_SYNC_800,
  parameter int H_BACK      = H_BACK_800,
  parameter int H_ACTIVE    = H_ACT_800,
  parameter int H_PERIOD    = H_PER_800,
  parameter int V_SYNC      = V_SYNC_600,
  parameter int V_BACK      = V_BACK_600,
  parameter int V_ACTIVE    = V_ACT_600,
  parameter int V_PERIOD    = V_PER_600,
  parameter int PIX_DELAY   = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        reset_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  input  logic        i_err_clear,
  output logic        o_pix_valid,
  output logic [10:0] o_pix_x,
  output logic [10:0] o_pix_y,
  output logic [11:0] o_pix_rgb,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic [31:0] o_frame_checksum,
  output logic [15:0] o_frame_count,
  output logic        o_locked,
  output logic        o_err_hperiod,
  output logic        o_err_hsync,
  output logic        o_err_vperiod,
  output logic        o_err_vsync
);

  localparam int X_OFF = H_SYNC + H_BACK + PIX_DELAY;
  localparam int Y_OFF = V_SYNC + V_BACK;

  logic          hs_q, vs_q, clr_q;
  rgb444_t       rgb_q;
  logic          h_fall, h_rise, v_fall, v_rise;
  logic [CW-1:0] hcnt, vcnt;
  logic          e_hs, e_hp, e_vs, e_vp, viol;
  lock_st_e      st_q, st_d;
  logic [7:0]    good_q, good_d;
  logic          locked, open, done, in_win, pix_v;
  logic          cap_q, cap_d;
  logic [31:0]   acc_q, acc_d;
  logic [3:0]    err_q, err_d;

  // single input register stage on every pin
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      clr_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= i_hs;
      vs_q  <= i_vs;
      clr_q <= i_err_clear;
      rgb_q <= {i_red, i_green, i_blue};
    end
  end

  vga_sync_meter #(.W_SYNC(H_SYNC), .PERIOD(H_PERIOD)) u_h (
    .clk_vga(clk_vga), .reset_n(reset_n),
    .sync_i(hs_q), .step_i(1'b1),
    .fall_o(h_fall), .rise_o(h_rise), .cnt_o(hcnt),
    .err_width_o(e_hs), .err_period_o(e_hp)
  );

  vga_sync_meter #(.W_SYNC(V_SYNC), .PERIOD(V_PERIOD)) u_v (
    .clk_vga(clk_vga), .reset_n(reset_n),
    .sync_i(vs_q), .step_i(h_fall),
    .fall_o(v_fall), .rise_o(v_rise), .cnt_o(vcnt),
    .err_width_o(e_vs), .err_period_o(e_vp)
  );

  assign viol   = e_hs | e_hp | e_vs | e_vp;
  assign locked = (st_q == ST_LOCKED);
  assign in_win = (int'(hcnt) >= X_OFF)
               && (int'(hcnt) < X_OFF + H_ACTIVE)
               && (int'(vcnt) >= Y_OFF)
               && (int'(vcnt) < Y_OFF + V_ACTIVE);

  // lock FSM next state
  always_comb begin
    st_d   = st_q;
    good_d = good_q;
    unique case (st_q)
      ST_SEARCH: if (v_fall) begin
        st_d   = ST_MEASURE;
        good_d = '0;
      end
      ST_MEASURE: if (viol) begin
        st_d = ST_SEARCH;
      end else if (v_fall) begin
        good_d = good_q + 8'd1;
        if (int'(good_d) >= LOCK_FRAMES) st_d = ST_LOCKED;
      end
      ST_LOCKED: if (viol) st_d = ST_SEARCH;
      default: st_d = ST_SEARCH;
    endcase
  end

  // frame capture control and checksum accumulation
  always_comb begin
    open  = v_fall & locked & ~viol;
    done  = open & cap_q;
    pix_v = cap_q & locked & ~viol & in_win;
    cap_d = cap_q;
    if (v_fall) cap_d = open;
    else if (viol || !locked) cap_d = 1'b0;
    acc_d = acc_q;
    if (open) acc_d = '0;
    else if (pix_v) acc_d = acc_q + 32'(rgb_q);
  end

  // sticky error flags, set wins over clear, ignored in SEARCH
  always_comb begin
    err_d = err_q & {4{~clr_q}};
    if (st_q != ST_SEARCH) err_d = err_d | {e_hp, e_hs, e_vp, e_vs};
  end

  // control state registers
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_SEARCH;
      good_q <= '0;
      cap_q  <= 1'b0;
      acc_q  <= '0;
      err_q  <= '0;
    end else begin
      st_q   <= st_d;
      good_q <= good_d;
      cap_q  <= cap_d;
      acc_q  <= acc_d;
      err_q  <= err_d;
    end
  end

  // registered pixel and frame outputs
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      o_pix_valid      <= 1'b0;
      o_pix_x          <= '0;
      o_pix_y          <= '0;
      o_pix_rgb        <= '0;
      o_frame_start    <= 1'b0;
      o_frame_done     <= 1'b0;
      o_frame_checksum <= '0;
      o_frame_count    <= '0;
    end else begin
      o_pix_valid   <= pix_v;
      o_frame_start <= open;
      o_frame_done  <= done;
      if (pix_v) begin
        o_pix_x   <= hcnt - CW'(X_OFF);
        o_pix_y   <= vcnt - CW'(Y_OFF);
        o_pix_rgb <= rgb_q;
      end
      if (done) begin
        o_frame_checksum <= acc_q;
        o_frame_count    <= o_frame_count + 16'd1;
      end
    end
  end

  assign o_locked      = locked;
  assign o_err_hperiod = err_q[3];
  assign o_err_hsync   = err_q[2];
  assign o_err_vperiod = err_q[1];
  assign o_err_vsync   = err_q[0];

  logic unused_rise;
  assign unused_rise = h_rise ^ v_rise;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Scoreboard bench for vga_capture_monitor on a reduced timing mode:
// 20 clocks/line, 12 lines/frame, 8x4 active pixels.
module tb_vga_capture_monitor;

  localparam int HS = 4, HB = 3, HA = 8, HP = 20;
  localparam int VS = 3, VB = 2, VA = 4, VP = 12;
  localparam int NO = -1;
  // 32 pixels of 0x00F, and a single 0xF00 pixel
  localparam logic [31:0] CS_BLUE = 32'h0000_01E0;
  localparam logic [31:0] CS_DOT  = 32'h0000_0F00;

  logic        clk_vga = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_hs = 1'b1, i_vs = 1'b1, i_err_clear = 1'b0;
  logic [3:0]  i_red = '0, i_green = '0, i_blue = '0;
  logic        o_pix_valid, o_frame_start, o_frame_done, o_locked;
  logic [10:0] o_pix_x, o_pix_y;
  logic [11:0] o_pix_rgb;
  logic [31:0] o_frame_checksum;
  logic [15:0] o_frame_count;
  logic        o_err_hperiod, o_err_hsync, o_err_vperiod, o_err_vsync;

  always #5 clk_vga = ~clk_vga;

  vga_capture_monitor #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_PERIOD(HP),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_PERIOD(VP),
    .PIX_DELAY(1), .LOCK_FRAMES(2)
  ) dut (
    .clk_vga(clk_vga), .reset_n(reset_n),
    .i_hs(i_hs), .i_vs(i_vs),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .i_err_clear(i_err_clear),
    .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
    .o_pix_rgb(o_pix_rgb), .o_frame_start(o_frame_start),
    .o_frame_done(o_frame_done), .o_frame_checksum(o_frame_checksum),
    .o_frame_count(o_frame_count), .o_locked(o_locked),
    .o_err_hperiod(o_err_hperiod), .o_err_hsync(o_err_hsync),
    .o_err_vperiod(o_err_vperiod), .o_err_vsync(o_err_vsync)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] rgb;
  } pix_t;

  typedef struct packed {
    logic [31:0] cs;
    logic [15:0] cnt;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  int tests = 0, fails = 0;
  int starts_seen = 0, starts_exp = 0;
  int exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pix_val(input int pat, input int x,
                                          input int y);
    if (pat == 1) return 12'h00F;
    if (pat == 2 && x == 0 && y == 0) return 12'hF00;
    return 12'h000;
  endfunction

  task automatic chk_rst_outputs();
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_count", 32'(o_frame_count), 0);
    chk("rst_checksum", o_frame_checksum, 0);
    chk("rst_pix_valid", 32'(o_pix_valid), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    chk("rst_errs", 32'({o_err_hperiod, o_err_hsync,
                        o_err_vperiod, o_err_vsync}), 0);
  endtask

  // one frame starting with a Vs fall at line 0; cap marks frames
  // whose active pixels and checksum are expected at the outputs
  task automatic frame(input int pat, input bit cap, input bit st,
                       input logic [31:0] cs, input int vsl,
                       input int bad_line, input int clr_line,
                       input int clr_col, input int rst_line,
                       input int stall_line);
    int hp, x, y;
    logic [11:0] v;
    bit act;
    if (st) starts_exp++;
    for (int l = 0; l < VP; l++) begin
      hp = (l == bad_line) ? HP - 1 : HP;
      for (int c = 0; c < hp; c++) begin
        @(negedge clk_vga);
        reset_n = 1'b1;
        x = c - HS - HB - 1;
        y = l - VS - VB;
        act = (x >= 0 && x < HA && y >= 0 && y < VA);
        v = act ? pix_val(pat, x, y) : 12'h000;
        i_hs = (c >= HS);
        i_vs = (l >= vsl);
        i_err_clear = (l == clr_line && c == clr_col);
        {i_red, i_green, i_blue} = v;
        if (cap && act) pq.push_back({11'(x), 11'(y), v});
        if (l == rst_line && c == 10) begin
          reset_n = 1'b0;
          #1;
          chk_rst_outputs();
          exp_cnt = 0;
        end
        if (l == stall_line && c == hp - 1)
          repeat (2100) @(negedge clk_vga);
      end
    end
    if (cap) begin
      exp_cnt++;
      fq.push_back({cs, 16'(exp_cnt)});
    end
  endtask

  task automatic plain(input int pat);
    frame(pat, 1'b0, 1'b0, 32'h0, VS, NO, NO, NO, NO, NO);
  endtask

  // monitor: pop expected responses whenever the DUT presents one
  always @(negedge clk_vga) begin
    pix_t e;
    frm_t f;
    if (o_pix_valid) begin
      tests++;
      if (pq.size() == 0) begin
        fails++;
        $display("FAIL pix_extra: got x=%0d y=%0d rgb=%h want none",
                 o_pix_x, o_pix_y, o_pix_rgb);
      end else begin
        e = pq.pop_front();
        if ({o_pix_x, o_pix_y, o_pix_rgb} !== e) begin
          fails++;
          $display("FAIL pix: got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                   o_pix_x, o_pix_y, o_pix_rgb, e.x, e.y, e.rgb);
        end
      end
    end
    if (o_frame_done) begin
      tests++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL done_extra: got cs=%h cnt=%0d want none",
                 o_frame_checksum, o_frame_count);
      end else begin
        f = fq.pop_front();
        if ({o_frame_checksum, o_frame_count} !== f) begin
          fails++;
          $display("FAIL done: got cs=%h cnt=%0d want cs=%h cnt=%0d",
                   o_frame_checksum, o_frame_count, f.cs, f.cnt);
        end
      end
    end
    if (o_frame_start) starts_seen++;
  end

  initial begin
    repeat (3) @(negedge clk_vga);
    chk_rst_outputs();
    chk("rst_start", 32'(o_frame_start), 0);
    // nominal lock: locked after the 3rd Vs fall
    plain(1);
    plain(1);
    chk("lock_after2", 32'(o_locked), 0);
    plain(1);
    chk("lock_after3", 32'(o_locked), 1);
    frame(1, 1'b1, 1'b1, CS_BLUE, VS, NO, NO, NO, NO, NO);
    frame(1, 1'b1, 1'b1, CS_BLUE, VS, NO, NO, NO, NO, NO);
    frame(1, 1'b1, 1'b1, CS_BLUE, VS, NO, NO, NO, NO, NO);
    chk("nom_errs", 32'({o_err_hperiod, o_err_hsync,
                        o_err_vperiod, o_err_vsync}), 0);
    // single-dot frame
    frame(2, 1'b1, 1'b1, CS_DOT, VS, NO, NO, NO, NO, NO);
    // short line while locked
    frame(1, 1'b0, 1'b1, 32'h0, VS, 1, NO, NO, NO, NO);
    chk("hper_flag", 32'(o_err_hperiod), 1);
    chk("hper_unlock", 32'(o_locked), 0);
    plain(1);
    plain(1);
    chk("hper_relock_early", 32'(o_locked), 0);
    plain(1);
    chk("hper_relock", 32'(o_locked), 1);
    chk("hper_sticky", 32'(o_err_hperiod), 1);
    frame(1, 1'b1, 1'b1, CS_BLUE, VS, NO, NO, NO, NO, NO);
    // short Vs while locked, then clear
    frame(1, 1'b0, 1'b1, 32'h0, VS - 1, NO, NO, NO, NO, NO);
    chk("vs_flag", 32'(o_err_vsync), 1);
    chk("vs_unlock", 32'(o_locked), 0);
    frame(1, 1'b0, 1'b0, 32'h0, VS, NO, 0, 5, NO, NO);
    chk("vs_cleared", 32'(o_err_vsync), 0);
    chk("hp_cleared", 32'(o_err_hperiod), 0);
    // clear coincident with a new violation in MEASURE
    frame(1, 1'b0, 1'b0, 32'h0, VS - 1, NO, 2, 0, NO, NO);
    chk("vs_set_wins", 32'(o_err_vsync), 1);
    chk("vs_meas_unlock", 32'(o_locked), 0);
    plain(1);
    plain(1);
    plain(1);
    chk("vs_relock", 32'(o_locked), 1);
    // reset mid-frame while locked
    frame(1, 1'b0, 1'b1, 32'h0, VS, NO, NO, NO, 4, NO);
    plain(1);
    plain(1);
    chk("rst_relock_early", 32'(o_locked), 0);
    plain(1);
    chk("rst_relock", 32'(o_locked), 1);
    frame(1, 1'b1, 1'b1, CS_BLUE, VS, NO, NO, NO, NO, NO);
    // Hs stuck high until the line counter saturates
    frame(1, 1'b0, 1'b1, 32'h0, VS, NO, NO, NO, NO, 4);
    chk("sat_flag", 32'(o_err_hperiod), 1);
    chk("sat_unlock", 32'(o_locked), 0);
    plain(1);
    repeat (20) @(negedge clk_vga);
    chk("pix_left", 32'(pq.size()), 0);
    chk("done_left", 32'(fq.size()), 0);
    chk("starts", 32'(starts_seen), 32'(starts_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
